// File: rtl/game_pkg.sv
// Shared definitions for the master sequencer and the maze / LED / VGA sub-machines.
package game_pkg;

  // MASTER_STATE encoding seen by every sub-machine
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MAZE = 2'b01,
    ST_WIN  = 2'b10,
    ST_LED  = 2'b11
  } state_t;

  // Sub-machine status value meaning "finished"
  localparam logic [3:0] STATUS_DONE = 4'hF;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes a raw button, debounces it and emits a one-cycle pulse on each debounced press.
module btn_debounce
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic BTN_IN,
  output logic BTN_LEVEL,
  output logic BTN_PRESS
);

  localparam int unsigned   CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level_d;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer for the asynchronous button input
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= BTN_IN;
      sync2 <= sync1;
    end
  end

  // Accept a level change only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt       <= '0;
      BTN_LEVEL <= 1'b0;
    end else if (sync2 != BTN_LEVEL) begin
      if (cnt == CNT_LAST) begin
        BTN_LEVEL <= sync2;
        cnt       <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

  // Registered rising-edge pulse on the debounced level; releases give nothing
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      level_d   <= 1'b0;
      BTN_PRESS <= 1'b0;
    end else begin
      level_d   <= BTN_LEVEL;
      BTN_PRESS <= BTN_LEVEL & ~level_d;
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Master sequencer: debounced buttons drive the IDLE/MAZE/WIN/LED state shared with the sub-machines,
// with a timed WIN display, BTNC abort and a saturating win counter.
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned WIN_HOLD_CYCLES = 500000000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BTNL,
  input  logic       BTNC,
  input  logic       BTNR,
  input  logic [3:0] MAZE_STATUS,
  input  logic [3:0] LED_STATUS,
  output logic [1:0] MASTER_STATE,
  output logic       WIN_PULSE,
  output logic [7:0] WIN_COUNT
);

  localparam int unsigned   HW        = cnt_width(WIN_HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(WIN_HOLD_CYCLES - 1);

  logic          press_l;
  logic          press_c;
  logic          press_r;
  state_t        state;
  state_t        state_next;
  logic          win_evt;
  logic [HW-1:0] hold;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_l (
    .CLK(CLK), .RESET(RESET), .BTN_IN(BTNL), .BTN_LEVEL(), .BTN_PRESS(press_l)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_c (
    .CLK(CLK), .RESET(RESET), .BTN_IN(BTNC), .BTN_LEVEL(), .BTN_PRESS(press_c)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_r (
    .CLK(CLK), .RESET(RESET), .BTN_IN(BTNR), .BTN_LEVEL(), .BTN_PRESS(press_r)
  );

  assign MASTER_STATE = state;

  // Next-state decode; a completion is the only path that raises win_evt
  always_comb begin
    state_next = state;
    win_evt    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (press_c)      state_next = ST_WIN;
        else if (press_l) state_next = ST_LED;
        else if (press_r) state_next = ST_MAZE;
      end
      ST_MAZE: begin
        if (MAZE_STATUS == STATUS_DONE) begin
          state_next = ST_WIN;
          win_evt    = 1'b1;
        end else if (press_c) begin
          state_next = ST_IDLE;
        end
      end
      ST_LED: begin
        if (LED_STATUS == STATUS_DONE) begin
          state_next = ST_WIN;
          win_evt    = 1'b1;
        end else if (press_c) begin
          state_next = ST_IDLE;
        end
      end
      ST_WIN: begin
        if (hold == HOLD_LAST) state_next = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= ST_IDLE;
    else        state <= state_next;
  end

  // WIN hold timer: zero on the first WIN cycle, counts while WIN persists
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)               hold <= '0;
    else if (state != ST_WIN) hold <= '0;
    else                      hold <= hold + 1'b1;
  end

  // Completion pulse and saturating win counter
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      WIN_PULSE <= 1'b0;
      WIN_COUNT <= '0;
    end else begin
      WIN_PULSE <= win_evt;
      if (win_evt && (WIN_COUNT != 8'hFF)) WIN_COUNT <= WIN_COUNT + 8'd1;
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with a due-cycle scoreboard of expected outputs.
module tb_game_sequencer;
  import game_pkg::*;

  localparam int unsigned DEB  = 4;
  localparam int unsigned HOLD = 16;

  typedef logic [8*12-1:0] tag_t;

  typedef struct {
    tag_t        tag;
    int unsigned due;
    logic [1:0]  st;
    logic        pulse;
    logic [7:0]  cnt;
    bit          chk_press;
    logic        press;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       BTNL, BTNC, BTNR;
  logic [3:0] MAZE_STATUS, LED_STATUS;
  logic [1:0] MASTER_STATE;
  logic       WIN_PULSE;
  logic [7:0] WIN_COUNT;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  logic [7:0]  model_cnt;
  exp_t        sb[$];

  game_sequencer #(.DEBOUNCE_CYCLES(DEB), .WIN_HOLD_CYCLES(HOLD)) dut (
    .CLK(CLK), .RESET(RESET), .BTNL(BTNL), .BTNC(BTNC), .BTNR(BTNR),
    .MAZE_STATUS(MAZE_STATUS), .LED_STATUS(LED_STATUS),
    .MASTER_STATE(MASTER_STATE), .WIN_PULSE(WIN_PULSE), .WIN_COUNT(WIN_COUNT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no finish, expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  task automatic cmp(input tag_t tag, input tag_t what, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %0s %0s: observed %0h, expected %0h (cycle %0d)", tag, what, obs, exp, cyc);
    end
  endtask

  task automatic expect_at(input tag_t tag, input int unsigned d, input logic [1:0] st,
                           input logic p, input bit cp = 1'b0, input logic pr = 1'b0);
    exp_t e;
    e.tag = tag; e.due = cyc + d; e.st = st; e.pulse = p; e.cnt = model_cnt;
    e.chk_press = cp; e.press = pr;
    sb.push_back(e);
  endtask

  // Advance one clock; compare every scoreboard entry that has come due
  task automatic tick();
    exp_t e;
    @(posedge CLK);
    #1;
    cyc++;
    while (sb.size() != 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      cmp(e.tag, "state", {6'b0, MASTER_STATE}, {6'b0, e.st});
      cmp(e.tag, "pulse", {7'b0, WIN_PULSE}, {7'b0, e.pulse});
      cmp(e.tag, "count", WIN_COUNT, e.cnt);
      if (e.chk_press) cmp(e.tag, "press_r", {7'b0, dut.press_r}, {7'b0, e.press});
    end
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic enter_led();
    BTNL = 1'b1;
    expect_at("enter_led", 7, ST_IDLE, 1'b0);
    expect_at("enter_led", 8, ST_LED, 1'b0);
    run(8);
    BTNL = 1'b0;
    for (int unsigned d = 1; d <= 8; d++) expect_at("led_rel", d, ST_LED, 1'b0);
    run(8);
  endtask

  initial begin
    RESET = 1'b0; BTNL = 1'b0; BTNC = 1'b0; BTNR = 1'b0;
    MAZE_STATUS = '0; LED_STATUS = '0;
    model_cnt = 8'd0;

    #3;
    cmp("reset", "state", {6'b0, MASTER_STATE}, 8'h00);
    cmp("reset", "pulse", {7'b0, WIN_PULSE}, 8'h00);
    cmp("reset", "count", WIN_COUNT, 8'h00);
    run(2);
    RESET = 1'b1;

    // Glitch of 3 cycles on BTNR must not register
    BTNR = 1'b1;
    for (int unsigned d = 1; d <= 9; d++) expect_at("glitch", d, ST_IDLE, 1'b0, 1'b1, 1'b0);
    run(3);
    BTNR = 1'b0;
    run(6);

    // Held BTNR: PRESS in cycle 7 only, MAZE from cycle 8
    BTNR = 1'b1;
    for (int unsigned d = 1; d <= 6; d++) expect_at("deb_lat", d, ST_IDLE, 1'b0, 1'b1, 1'b0);
    expect_at("deb_lat", 7, ST_IDLE, 1'b0, 1'b1, 1'b1);
    expect_at("deb_lat", 8, ST_MAZE, 1'b0, 1'b1, 1'b0);
    run(8);
    BTNR = 1'b0;
    for (int unsigned d = 1; d <= 10; d++) expect_at("release", d, ST_MAZE, 1'b0, 1'b1, 1'b0);
    run(10);

    // LED status is ignored while in MAZE
    LED_STATUS = STATUS_DONE;
    for (int unsigned d = 1; d <= 3; d++) expect_at("cross_ign", d, ST_MAZE, 1'b0);
    run(3);
    LED_STATUS = '0;

    // Maze completion: WIN with pulse, held exactly HOLD cycles
    MAZE_STATUS = STATUS_DONE;
    model_cnt = 8'd1;
    expect_at("maze_win", 1, ST_WIN, 1'b1);
    expect_at("maze_win", 2, ST_WIN, 1'b0);
    expect_at("win_hold", 16, ST_WIN, 1'b0);
    expect_at("win_end", 17, ST_IDLE, 1'b0);
    run(1);
    MAZE_STATUS = '0;
    run(16);

    // BTNL+BTNC together in IDLE: C wins, demo WIN without count
    BTNL = 1'b1; BTNC = 1'b1;
    expect_at("prio_cl", 7, ST_IDLE, 1'b0);
    expect_at("prio_cl", 8, ST_WIN, 1'b0);
    expect_at("demo_hold", 23, ST_WIN, 1'b0);
    expect_at("demo_end", 24, ST_IDLE, 1'b0);
    run(8);
    BTNL = 1'b0; BTNC = 1'b0;
    run(16);

    // LED completion and pressC in the same cycle: completion wins
    enter_led();
    BTNC = 1'b1;
    expect_at("led_pre", 7, ST_LED, 1'b0);
    run(7);
    LED_STATUS = STATUS_DONE;
    model_cnt = 8'd2;
    expect_at("led_win", 1, ST_WIN, 1'b1);
    expect_at("led_hold", 16, ST_WIN, 1'b0);
    expect_at("led_end", 17, ST_IDLE, 1'b0);
    run(1);
    LED_STATUS = '0; BTNC = 1'b0;
    run(16);

    // Abort from LED with pressC alone
    enter_led();
    BTNC = 1'b1;
    expect_at("abort", 7, ST_LED, 1'b0);
    expect_at("abort", 8, ST_IDLE, 1'b0);
    run(8);
    BTNC = 1'b0;
    for (int unsigned d = 1; d <= 8; d++) expect_at("abort_rel", d, ST_IDLE, 1'b0);
    run(8);

    // 260 maze wins: counter saturates, pulse keeps firing
    for (int unsigned i = 0; i < 260; i++) begin
      BTNR = 1'b1;
      expect_at("sat_maze", 8, ST_MAZE, 1'b0);
      run(8);
      BTNR = 1'b0;
      MAZE_STATUS = STATUS_DONE;
      if (model_cnt != 8'hFF) model_cnt = model_cnt + 8'd1;
      expect_at("sat_win", 1, ST_WIN, 1'b1);
      expect_at("sat_end", 17, ST_IDLE, 1'b0);
      run(1);
      MAZE_STATUS = '0;
      run(16);
    end
    cmp("saturate", "count", WIN_COUNT, 8'hFF);

    // Asynchronous reset in the middle of a WIN hold, BTNR kept held throughout
    BTNR = 1'b1;
    expect_at("rst_maze", 8, ST_MAZE, 1'b0);
    run(8);
    MAZE_STATUS = STATUS_DONE;
    expect_at("rst_win", 1, ST_WIN, 1'b1);
    run(1);
    MAZE_STATUS = '0;
    run(5);
    #2;
    RESET = 1'b0;
    #1;
    cmp("async_rst", "state", {6'b0, MASTER_STATE}, 8'h00);
    cmp("async_rst", "pulse", {7'b0, WIN_PULSE}, 8'h00);
    cmp("async_rst", "count", WIN_COUNT, 8'h00);
    model_cnt = 8'd0;
    run(2);
    RESET = 1'b1;
    for (int unsigned d = 1; d <= 6; d++) expect_at("post_rst", d, ST_IDLE, 1'b0, 1'b1, 1'b0);
    expect_at("post_rst", 7, ST_IDLE, 1'b0, 1'b1, 1'b1);
    expect_at("post_rst", 8, ST_MAZE, 1'b0, 1'b1, 1'b0);
    run(8);
    BTNR = 1'b0;
    run(2);

    n_assert++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL drain: observed %0d pending entries, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Master sequencer for the linked-state-machine game.
- Debounces and edge-detects BTNL/BTNC/BTNR and drives the 2-bit MASTER_STATE consumed by the maze, LED-display and VGA-display sub-machines.
- Adds what the bare master FSM lacks: a timed win display returning to idle, BTNC abort from a running game, and a saturating win counter.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable synchronized samples needed to accept a button level change (10 ms @ 100 MHz).
- WIN_HOLD_CYCLES, 500000000: cycles spent in WIN before the automatic return to IDLE (5 s @ 100 MHz).

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-low reset.
- BTNL  in  1  raw button, asynchronous to CLK.
- BTNC  in  1  raw button, asynchronous to CLK.
- BTNR  in  1  raw button, asynchronous to CLK.
- MAZE_STATUS  in  4  maze sub-machine state; 4'hF = complete.
- LED_STATUS  in  4  LED sub-machine state; 4'hF = fully lit.
- MASTER_STATE  out  2  00 IDLE, 01 MAZE, 10 WIN, 11 LED; driven directly from the state register.
- WIN_PULSE  out  1  one-cycle pulse on each game-completion entry to WIN.
- WIN_COUNT  out  8  saturating count of completed games.

Behaviour:
- Reset (RESET low, asynchronous): MASTER_STATE=00, WIN_PULSE=0, WIN_COUNT=0.
  - Also cleared: hold counter, all debounce counters and synchronizers, debounced levels = 0.
  - Release is synchronous in effect; first transition is possible on the first CLK edge after RESET goes high.
- Button path, per button:
  - 2-FF synchronizer feeding a debounce counter.
  - If the synchronized value differs from the debounced level, the counter increments; otherwise the counter clears.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level flips and the counter clears.
  - PRESS is a registered one-cycle pulse on a debounced rising edge. Releases produce no pulse.
  - Latency: raw held high from edge 0 gives PRESS high during cycle DEBOUNCE_CYCLES+3 only.
  - Glitches shorter than DEBOUNCE_CYCLES cycles produce no PRESS.
- FSM: registered state. A transition decided on edge k shows on MASTER_STATE after edge k.
  - IDLE:
    - pressC -> WIN (demo entry; no WIN_PULSE, no count).
    - else pressL -> LED.
    - else pressR -> MAZE.
    - Priority C > L > R for simultaneous presses.
  - MAZE:
    - MAZE_STATUS==4'hF -> WIN with WIN_PULSE.
    - else pressC -> IDLE (abort).
    - Completion beats abort in the same cycle. L/R presses are ignored.
  - LED:
    - LED_STATUS==4'hF -> WIN with WIN_PULSE.
    - else pressC -> IDLE.
    - Same priority as MAZE.
  - WIN:
    - Hold counter clears on entry and counts every cycle.
    - Leaves to IDLE when the counter reaches WIN_HOLD_CYCLES-1, so WIN lasts exactly WIN_HOLD_CYCLES cycles.
    - All presses are ignored.
  - Unreachable encodings do not exist (2 bits, all used). No default recovery is needed beyond reset.
- WIN_PULSE: registered, high for the single cycle in which MASTER_STATE first reads 10 after a completion.
- WIN_COUNT: increments with WIN_PULSE; saturates at 8'hFF and does not wrap.
- Status inputs are sampled only in their own game state. A 4'hF on the other game's status is ignored.
- Status is level-based: if status is still 4'hF when re-entering a game, completion fires on the first cycle in that state. Sub-machines are responsible for clearing their status on MASTER_STATE change.
- Counter widths: $clog2 of the parameter, minimum 1.

Decomposition:
- Shared package game_pkg:
  - State constants ST_IDLE=2'b00, ST_MAZE=2'b01, ST_WIN=2'b10, ST_LED=2'b11.
  - STATUS_DONE=4'hF.
  - Imported by this block and by the maze/LED/VGA sub-machines.
- One sub-module: btn_debounce.
  - Ports: CLK, RESET, BTN_IN, BTN_LEVEL, BTN_PRESS; parameter DEBOUNCE_CYCLES.
  - Instantiated three times.
- FSM, hold counter and win counter live in game_sequencer.

Test Plan (bench uses DEBOUNCE_CYCLES=4, WIN_HOLD_CYCLES=16):
- Debounce: BTNR high for 3 cycles then low -> no PRESS, MASTER_STATE stays 00. BTNR held high -> PRESS in cycle 7 only; MASTER_STATE=01 from cycle 8.
- Maze win: in MAZE, MAZE_STATUS=4'hF -> MASTER_STATE=10 next cycle, WIN_PULSE high 1 cycle, WIN_COUNT=1. Exactly 16 cycles later MASTER_STATE=00.
- Priority/abort: BTNL and BTNC pressed together in IDLE -> 10 with WIN_COUNT unchanged. In LED, LED_STATUS=4'hF and pressC in the same cycle -> 10 with WIN_PULSE. In LED, pressC alone -> 00.
- Cross-status ignore: in MAZE, LED_STATUS=4'hF -> stays 01, no pulse.
- Saturation: 260 maze wins -> WIN_COUNT=8'hFF, no wrap; WIN_PULSE still pulses.
- Reset mid-operation: RESET low asynchronously mid-WIN hold (no CLK edge) -> outputs 00/0/0 immediately. After release, a held button produces a fresh PRESS only after full debounce latency.
